cpx_rcv_buf: RTL

Core-side CPX receive buffer that sits directly downstream of the CPX arbiter for one destination core. It captures every CPX beat the arbiter delivers, queues it in a small FIFO, and presents packets to the core's load/store and ifill logic. It generates the registered per-core `cpx_stall_o` that the arbiter consumes as its stall input, with enough skid to absorb an in-flight beat plus an atomic IFILL1/IFILL2 partner. The buffer never releases IFILL1 to the core until its IFILL2 partner is also buffered.

---
 rtl/cpx_rcv_buf.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cpx_rcv_buf.sv
// CPX receive buffer: queues arbiter beats for one core, drives the arbiter stall and holds IFILL1 until IFILL2 is buffered.
// Define CPX_RCV_BUF_CHK_EN to build the sticky overflow and broken-pair checkers; otherwise both flags read 0.
module cpx_rcv_buf #(
  parameter int DEPTH = 8,
  parameter int PKT_W = 145
) (
  input  logic                     rclk,
  input  logic                     rst_l,
  input  logic                     cpx_vld_i,
  input  logic                     cpx_atom_i,
  input  logic [PKT_W-1:0]         cpx_data_i,
  output logic                     cpx_stall_o,
  output logic                     pkt_vld_o,
  output logic                     pkt_atom_o,
  output logic [PKT_W-1:0]         pkt_data_o,
  input  logic                     pkt_rdy_i,
  output logic [$clog2(DEPTH):0]   occ_o,
  output logic                     ovf_err_o,
  output logic                     pair_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_STALL = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] OCC_PAIR  = (AW+1)'(2);
  localparam logic [AW:0] OCC_ONE   = (AW+1)'(1);

  // Each entry carries the atom flag above the payload.
  logic [PKT_W:0]  mem [DEPTH];
  logic [PKT_W:0]  head_word;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW:0]     occ_reg, occ_next;
  logic            head_atom;
  logic            occ_nz;
  logic            push;
  logic            pop;

  assign head_word = mem[rd_ptr_reg];
  assign head_atom = head_word[PKT_W];
  assign occ_nz    = (occ_reg != '0);

  // An IFILL1 head stays invisible until its partner sits behind it.
  assign pkt_vld_o  = occ_nz && (!head_atom || (occ_reg >= OCC_PAIR));
  assign pkt_atom_o = occ_nz && head_atom;
  assign pkt_data_o = occ_nz ? head_word[PKT_W-1:0] : '0;

  assign cpx_stall_o = (occ_reg >= OCC_STALL);
  assign occ_o       = occ_reg;

  assign pop  = pkt_vld_o && pkt_rdy_i;
  assign push = cpx_vld_i && ((occ_reg != OCC_FULL) || pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   occ_next = occ_reg + OCC_ONE;
      2'b01:   occ_next = occ_reg - OCC_ONE;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
    end
  end

  // Storage is not reset; stale entries are never visible because outputs gate on occupancy.
  always_ff @(posedge rclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cpx_atom_i, cpx_data_i};
    end
  end

`ifdef CPX_RCV_BUF_CHK_EN
  logic expect_reg, expect_next;
  logic ovf_err_reg, ovf_err_next;
  logic pair_err_reg, pair_err_next;

  always_comb begin
    expect_next   = push && cpx_atom_i;
    ovf_err_next  = ovf_err_reg;
    pair_err_next = pair_err_reg;
    if (cpx_vld_i && (occ_reg == OCC_FULL) && !pop) begin
      ovf_err_next = 1'b1;
    end
    // The partner slot must carry a non-atom beat.
    if (expect_reg && (!cpx_vld_i || cpx_atom_i)) begin
      pair_err_next = 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      expect_reg   <= 1'b0;
      ovf_err_reg  <= 1'b0;
      pair_err_reg <= 1'b0;
    end else begin
      expect_reg   <= expect_next;
      ovf_err_reg  <= ovf_err_next;
      pair_err_reg <= pair_err_next;
    end
  end

  assign ovf_err_o  = ovf_err_reg;
  assign pair_err_o = pair_err_reg;
`else
  assign ovf_err_o  = 1'b0;
  assign pair_err_o = 1'b0;
`endif

endmodule
